// File: rtl/bandai2003_bus_seq_if.sv
// Host command/response channel and cartridge pin bundle for the BANDAI2003 bus sequencer.
interface bandai2003_bus_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       unlocked;
    logic       CEn;
    logic       WEn;
    logic       OEn;
    logic       SSn;
    logic [7:0] ADDR;
    logic [7:0] DQ_O;
    logic       DQ_OE;
    logic [7:0] DQ_I;
    logic       SO;

    // Sequencer view: takes commands, drives the cartridge pins.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, DQ_I, SO,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata, unlocked,
               CEn, WEn, OEn, SSn, ADDR, DQ_O, DQ_OE
    );

    // Host / cartridge-side view.
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, DQ_I, SO,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, unlocked,
               CEn, WEn, OEn, SSn, ADDR, DQ_O, DQ_OE
    );
endinterface

// File: rtl/bandai2003_bus_seq.sv
// Host-side bus sequencer for the BANDAI2003 mapper: unlock handshake, register and window cycles.
// Optional SO bitstream verification during unlock: define BANDAI_SO_CHECK_EN.
module bandai2003_bus_seq #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    bandai2003_bus_seq_if.slave   bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_UNLOCK = 3'd0;
    localparam logic [OP_W-1:0] OP_REG_WR = 3'd1;
    localparam logic [OP_W-1:0] OP_REG_RD = 3'd2;
    localparam logic [OP_W-1:0] OP_MEM_RD = 3'd3;
    localparam logic [OP_W-1:0] OP_MEM_WR = 3'd4;

    localparam logic [DATA_W-1:0] KEY_A     = 8'h5A;
    localparam logic [DATA_W-1:0] KEY_B     = 8'hA5;
    localparam logic [DATA_W-1:0] ADDR_IDLE = 8'hFF;

`ifdef BANDAI_SO_CHECK_EN
    localparam int unsigned     SO_W   = 18;
    localparam int unsigned     BITC_W = 5;
    localparam logic [SO_W-1:0] SO_KEY = 18'h05140;
`endif

    typedef enum logic [2:0] {
        IDLE, UNL_A, UNL_B, UNL_CHK, SETUP, STROBE, HOLD, RESP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [OP_W-1:0]     op_q, op_n;
    logic [DATA_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                err_q, err_n;
`ifdef BANDAI_SO_CHECK_EN
    logic [SO_W-1:0]     so_cap, so_cap_n;
    logic [BITC_W-1:0]   bit_cnt, bit_cnt_n;
`endif

    logic                cmd_ready_d, rsp_valid_d, rsp_err_d, unlocked_d;
    logic                ce_n_d, we_n_d, oe_n_d, ss_n_d, dq_oe_d;
    logic [DATA_W-1:0]   rsp_rdata_d, addr_d, dq_o_d;
    logic                accept, is_wr, is_rd, is_reg;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign is_wr  = (op_q == OP_REG_WR) || (op_q == OP_MEM_WR);
    assign is_rd  = (op_q == OP_REG_RD) || (op_q == OP_MEM_RD);
    assign is_reg = (op_q == OP_REG_WR) || (op_q == OP_REG_RD);

    // Next state plus pin values; pins follow the state one cycle behind.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        op_n        = op_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rdata_n     = rdata_q;
        err_n       = err_q;
`ifdef BANDAI_SO_CHECK_EN
        so_cap_n    = so_cap;
        bit_cnt_n   = bit_cnt;
`endif
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        unlocked_d  = bus.unlocked;
        ce_n_d      = 1'b1;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        ss_n_d      = 1'b1;
        addr_d      = ADDR_IDLE;
        dq_o_d      = '0;
        dq_oe_d     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    op_n    = bus.cmd_op;
                    addr_n  = bus.cmd_addr;
                    wdata_n = bus.cmd_wdata;
                    rdata_n = '0;
                    err_n   = 1'b0;
                    // UNLOCK is legal only while locked, everything else only while unlocked.
                    if ((bus.cmd_op > OP_MEM_WR) || ((bus.cmd_op == OP_UNLOCK) == bus.unlocked)) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else if (bus.cmd_op == OP_UNLOCK) begin
                        state_n = UNL_A;
                    end else begin
                        state_n = SETUP;
                        cnt_n   = CNT_W'(SETUP_CYC);
                    end
                end
            end
            UNL_A: state_n = UNL_B;
            UNL_B: begin
`ifdef BANDAI_SO_CHECK_EN
                state_n   = UNL_CHK;
                bit_cnt_n = BITC_W'(SO_W);
                so_cap_n  = '0;
`else
                state_n   = RESP;
`endif
            end
`ifdef BANDAI_SO_CHECK_EN
            UNL_CHK: begin
                so_cap_n  = {bus.SO, so_cap[SO_W-1:1]};
                bit_cnt_n = bit_cnt - BITC_W'(1);
                if (bit_cnt == BITC_W'(1)) begin
                    state_n = RESP;
                    err_n   = (so_cap_n != SO_KEY);
                end
            end
`endif
            SETUP: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = STROBE;
                    cnt_n   = CNT_W'(STROBE_CYC);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = HOLD;
                    cnt_n   = CNT_W'(HOLD_CYC);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                // OEn is still low only at the edge that closes the last strobe cycle.
                if (!bus.OEn) rdata_n = bus.DQ_I;
                if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        cmd_ready_d = (state_n == IDLE);

        case (state)
            UNL_A: addr_d = KEY_A;
            UNL_B: addr_d = KEY_B;
            SETUP, STROBE, HOLD: begin
                addr_d  = addr_q;
                ce_n_d  = 1'b0;
                ss_n_d  = !is_reg;
                dq_oe_d = is_wr;
                dq_o_d  = is_wr ? wdata_q : '0;
                if (state == STROBE) begin
                    we_n_d = !is_wr;
                    oe_n_d = !is_rd;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (is_rd && !err_q) ? rdata_q : '0;
                if ((op_q == OP_UNLOCK) && !err_q) unlocked_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state and captured command.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef BANDAI_SO_CHECK_EN
            so_cap  <= '0;
            bit_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op_q    <= op_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
`ifdef BANDAI_SO_CHECK_EN
            so_cap  <= so_cap_n;
            bit_cnt <= bit_cnt_n;
`endif
        end
    end

    // Registered host and cartridge outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.unlocked  <= 1'b0;
            bus.CEn       <= 1'b1;
            bus.WEn       <= 1'b1;
            bus.OEn       <= 1'b1;
            bus.SSn       <= 1'b1;
            bus.ADDR      <= ADDR_IDLE;
            bus.DQ_O      <= '0;
            bus.DQ_OE     <= 1'b0;
        end else begin
            bus.cmd_ready <= cmd_ready_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_err   <= rsp_err_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.unlocked  <= unlocked_d;
            bus.CEn       <= ce_n_d;
            bus.WEn       <= we_n_d;
            bus.OEn       <= oe_n_d;
            bus.SSn       <= ss_n_d;
            bus.ADDR      <= addr_d;
            bus.DQ_O      <= dq_o_d;
            bus.DQ_OE     <= dq_oe_d;
        end
    end

endmodule

// File: tb/tb_bandai2003_bus_seq.sv
// Directed bench for bandai2003_bus_seq with a small behavioural BANDAI2003 mapper model.
module tb_bandai2003_bus_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bandai2003_bus_seq_if bus();

    bandai2003_bus_seq #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

`ifdef BANDAI_SO_CHECK_EN
    localparam int UNL_LAT = 21;
`else
    localparam int UNL_LAT = 3;
`endif
    localparam logic [17:0] SO_GOOD = 18'h05140;

    // Mapper model: registers by SSn=0, banked window (bank = reg C0[2:0]) by SSn=1.
    logic [7:0]   regs [256];
    logic [7:0]   ram  [128];
    logic [127:0] ram_wr = '0;
    logic [6:0]   raddr;
    assign raddr = {regs[8'hC0][2:0], bus.ADDR[7:4]};

    always_comb begin
        bus.DQ_I = 8'h00;
        if (!bus.OEn)
            bus.DQ_I = !bus.SSn ? regs[bus.ADDR]
                     : (ram_wr[raddr] ? ram[raddr] : ({1'b0, raddr} ^ 8'hA5));
    end

    always @(posedge bus.WEn) begin
        if (rst_n && !bus.CEn) begin
            if (!bus.SSn) regs[bus.ADDR] <= bus.DQ_O;
            else begin
                ram[raddr]    <= bus.DQ_O;
                ram_wr[raddr] <= 1'b1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          r_lat, n_ce, n_we, n_oe, n_both, n_ss0, n_ss1, viol;
    logic        r_found, r_err;
    logic [7:0]  r_rdata;
    logic [15:0] trace;

    // Issue one command and follow it cycle by cycle until its response.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [17:0] so_pat);
        int         k;
        int         so_idx;
        logic [7:0] prev_addr;
        logic       prev_stb;
        @(negedge clk);
        chk("ready_before_cmd", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("ready_drop", 32'(bus.cmd_ready), 0);
        n_ce = 0; n_we = 0; n_oe = 0; n_both = 0; n_ss0 = 0; n_ss1 = 0; viol = 0;
        trace = '0; r_found = 1'b0; r_lat = -1; r_err = 1'b0; r_rdata = '0;
        so_idx = -1; prev_addr = 8'hFF; prev_stb = 1'b1; k = 0;
        while (!r_found && k <= 40) begin
            if (!bus.CEn) n_ce++;
            if (!bus.WEn) n_we++;
            if (!bus.OEn) n_oe++;
            if (!bus.WEn && !bus.OEn) n_both++;
            if (!bus.CEn && !bus.SSn) n_ss0++;
            if (!bus.CEn && bus.SSn) n_ss1++;
            if ((!bus.WEn || !bus.OEn) && prev_stb && (bus.ADDR != prev_addr)) viol++;
            if ((bus.ADDR != prev_addr) && (bus.ADDR != 8'hFF)) trace = {trace[7:0], bus.ADDR};
            prev_addr = bus.ADDR;
            prev_stb  = bus.WEn && bus.OEn;
            if (bus.ADDR == 8'hA5) so_idx = 0;
            else if (so_idx >= 0 && so_idx < 17) so_idx++;
            bus.SO = (so_idx >= 0) ? so_pat[5'(so_idx)] : 1'b0;
            if (bus.rsp_valid) begin
                r_found = 1'b1;
                r_lat   = k;
                r_err   = bus.rsp_err;
                r_rdata = bus.rsp_rdata;
            end else begin
                k++;
                @(negedge clk);
            end
        end
        chk("rsp_seen", 32'(r_found), 1);
        @(negedge clk);
        chk("rsp_one_pulse", 32'(bus.rsp_valid), 0);
        chk("ready_back", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rsp;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.SO        = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_cen",      32'(bus.CEn), 1);
        chk("rst_wen",      32'(bus.WEn), 1);
        chk("rst_oen",      32'(bus.OEn), 1);
        chk("rst_ssn",      32'(bus.SSn), 1);
        chk("rst_addr",     32'(bus.ADDR), 'hFF);
        chk("rst_dqo",      32'(bus.DQ_O), 0);
        chk("rst_dqoe",     32'(bus.DQ_OE), 0);
        chk("rst_ready",    32'(bus.cmd_ready), 1);
        chk("rst_rsp",      32'(bus.rsp_valid), 0);
        chk("rst_err",      32'(bus.rsp_err), 0);
        chk("rst_rdata",    32'(bus.rsp_rdata), 0);
        chk("rst_unlocked", 32'(bus.unlocked), 0);
        rst_n = 1'b1;

        // Access while locked
        run_cmd(3'd1, 8'hC2, 8'h05, SO_GOOD);
        chk("locked_lat", 32'(r_lat), 1);
        chk("locked_err", 32'(r_err), 1);
        chk("locked_ce",  32'(n_ce), 0);
        chk("locked_we",  32'(n_we), 0);

`ifdef BANDAI_SO_CHECK_EN
        // Corrupted SO bitstream
        run_cmd(3'd0, 8'h00, 8'h00, SO_GOOD ^ 18'h00100);
        chk("badso_lat",      32'(r_lat), 21);
        chk("badso_err",      32'(r_err), 1);
        chk("badso_unlocked", 32'(bus.unlocked), 0);
`endif

        // Unlock
        run_cmd(3'd0, 8'h00, 8'h00, SO_GOOD);
        chk("unl_trace",    32'(trace), 'h5AA5);
        chk("unl_lat",      32'(r_lat), UNL_LAT);
        chk("unl_err",      32'(r_err), 0);
        chk("unl_unlocked", 32'(bus.unlocked), 1);
        chk("unl_ce",       32'(n_ce), 0);

        // Register write then read back
        run_cmd(3'd1, 8'hC2, 8'h05, SO_GOOD);
        chk("regwr_lat",   32'(r_lat), 5);
        chk("regwr_err",   32'(r_err), 0);
        chk("regwr_we",    32'(n_we), 2);
        chk("regwr_oe",    32'(n_oe), 0);
        chk("regwr_ss0",   32'(n_ss0), 4);
        chk("regwr_ss1",   32'(n_ss1), 0);
        chk("regwr_viol",  32'(viol), 0);
        chk("regwr_rdata", 32'(r_rdata), 0);
        chk("regwr_model", 32'(regs[8'hC2]), 'h05);

        run_cmd(3'd2, 8'hC2, 8'h00, SO_GOOD);
        chk("regrd_lat",   32'(r_lat), 5);
        chk("regrd_rdata", 32'(r_rdata), 'h05);
        chk("regrd_oe",    32'(n_oe), 2);
        chk("regrd_we",    32'(n_we), 0);
        chk("regrd_both",  32'(n_both), 0);
        chk("regrd_ss0",   32'(n_ss0), 4);
        chk("regrd_viol",  32'(viol), 0);

        // Banked memory window
        run_cmd(3'd1, 8'hC0, 8'h01, SO_GOOD);
        chk("bank_err", 32'(r_err), 0);

        run_cmd(3'd3, 8'h40, 8'h00, SO_GOOD);
        chk("memrd_lat",   32'(r_lat), 5);
        chk("memrd_rdata", 32'(r_rdata), 'hB1);
        chk("memrd_oe",    32'(n_oe), 2);
        chk("memrd_ss1",   32'(n_ss1), 4);
        chk("memrd_trace", 32'(trace), 'h0040);

        run_cmd(3'd4, 8'h50, 8'h3C, SO_GOOD);
        chk("memwr_err", 32'(r_err), 0);
        chk("memwr_we",  32'(n_we), 2);
        chk("memwr_ss1", 32'(n_ss1), 4);

        run_cmd(3'd3, 8'h50, 8'h00, SO_GOOD);
        chk("memrd2_rdata", 32'(r_rdata), 'h3C);

        // Reset in the middle of a write strobe
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_addr  = 8'h60;
        bus.cmd_wdata = 8'hAA;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_strobe", 32'(bus.WEn), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_cen",      32'(bus.CEn), 1);
        chk("midrst_wen",      32'(bus.WEn), 1);
        chk("midrst_addr",     32'(bus.ADDR), 'hFF);
        chk("midrst_dqoe",     32'(bus.DQ_OE), 0);
        chk("midrst_unlocked", 32'(bus.unlocked), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        chk("midrst_no_rsp", 32'(n_rsp), 0);
        chk("midrst_still_locked", 32'(bus.unlocked), 0);

        run_cmd(3'd2, 8'hC2, 8'h00, SO_GOOD);
        chk("postrst_lat", 32'(r_lat), 1);
        chk("postrst_err", 32'(r_err), 1);

        // Re-unlock, then double unlock and illegal opcode
        run_cmd(3'd0, 8'h00, 8'h00, SO_GOOD);
        chk("reunl_err", 32'(r_err), 0);
        chk("reunl_unlocked", 32'(bus.unlocked), 1);

        run_cmd(3'd0, 8'h00, 8'h00, SO_GOOD);
        chk("dblunl_lat",      32'(r_lat), 1);
        chk("dblunl_err",      32'(r_err), 1);
        chk("dblunl_ce",       32'(n_ce), 0);
        chk("dblunl_trace",    32'(trace), 0);
        chk("dblunl_unlocked", 32'(bus.unlocked), 1);

        run_cmd(3'd7, 8'h12, 8'h34, SO_GOOD);
        chk("illop_lat", 32'(r_lat), 1);
        chk("illop_err", 32'(r_err), 1);
        chk("illop_ce",  32'(n_ce), 0);
        chk("illop_we",  32'(n_we), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
